// File: rtl/uart_pkt_framer.sv
// Packet framer in front of a byte-wide UART transmitter: buffers payload bytes and,
// on send, hands SYNC, LEN, payload and an XOR checksum to the UART one byte at a time.
module uart_pkt_framer #(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned LEN_BITS  = 5,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [7:0]          wr_data,
  input  logic                send,
  output logic                busy,
  output logic [LEN_BITS-1:0] buf_count,
  output logic                overflow,
  output logic                done,
  input  logic                txready,
  output logic                txen,
  output logic [7:0]          din
);

  localparam int unsigned IDX_BITS = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_BITS-1:0] MAX_CNT = LEN_BITS'(MAX_LEN);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] FLD_SYNC = 2'd0;
  localparam logic [1:0] FLD_LEN  = 2'd1;
  localparam logic [1:0] FLD_DATA = 2'd2;
  localparam logic [1:0] FLD_CHK  = 2'd3;

  logic [7:0] mem [MAX_LEN];

  logic [1:0]          state_q, state_d;
  logic [1:0]          field_q, field_d;
  logic [IDX_BITS-1:0] idx_q, idx_d;
  logic [7:0]          len_q, len_d;
  logic [7:0]          chk_q, chk_d;
  logic [LEN_BITS-1:0] count_q, count_d;
  logic                txen_q, txen_d;
  logic [7:0]          din_q, din_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic       wr_ok;
  logic       last_data;
  logic [7:0] cur_byte;
  logic [7:0] send_len;

  assign wr_ok     = wr_en && (state_q == ST_IDLE) && (count_q < MAX_CNT);
  assign last_data = (8'(idx_q) == (len_q - 8'd1));
  // A byte written in the same cycle as send belongs to this frame.
  assign send_len  = 8'(count_q) + {7'd0, wr_ok};

  always_comb begin
    cur_byte = SYNC_BYTE;
    case (field_q)
      FLD_SYNC: cur_byte = SYNC_BYTE;
      FLD_LEN:  cur_byte = len_q;
      FLD_DATA: cur_byte = mem[idx_q];
      FLD_CHK:  cur_byte = chk_q;
      default:  cur_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    idx_d   = idx_q;
    len_d   = len_q;
    chk_d   = chk_q;
    count_d = count_q;
    txen_d  = 1'b0;
    din_d   = din_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = wr_en && !wr_ok;

    if (wr_ok) begin
      count_d = count_q + LEN_BITS'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (send) begin
          len_d   = send_len;
          chk_d   = send_len;
          field_d = FLD_SYNC;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (txready) begin
          din_d   = cur_byte;
          txen_d  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!txready) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (txready) begin
          state_d = ST_ISSUE;
          case (field_q)
            FLD_SYNC: field_d = FLD_LEN;
            FLD_LEN: begin
              field_d = (len_q == 8'd0) ? FLD_CHK : FLD_DATA;
              idx_d   = '0;
            end
            FLD_DATA: begin
              chk_d = chk_q ^ mem[idx_q];
              if (last_data) begin
                field_d = FLD_CHK;
              end else begin
                idx_d = idx_q + IDX_BITS'(1);
              end
            end
            FLD_CHK: begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              count_d = '0;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      field_q <= FLD_SYNC;
      idx_q   <= '0;
      len_q   <= 8'd0;
      chk_q   <= 8'd0;
      count_q <= '0;
      txen_q  <= 1'b0;
      din_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      chk_q   <= chk_d;
      count_q <= count_d;
      txen_q  <= txen_d;
      din_q   <= din_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage needs no reset: buf_count alone says what is valid.
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem[IDX_BITS'(count_q)] <= wr_data;
    end
  end

  assign busy      = busy_q;
  assign buf_count = count_q;
  assign overflow  = ovf_q;
  assign done      = done_q;
  assign txen      = txen_q;
  assign din       = din_q;

endmodule
